// File: rtl/prefetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prefetch_pkg
//  Brief    : Shared defaults and queue entry layout for the instruction
//             prefetch buffer.
//  Revision : 1.0  initial release
// ============================================================================
package prefetch_pkg;

   localparam int c_DEF_ADDR_W = 9;
   localparam int c_DEF_DATA_W = 32;
   localparam int c_DEF_DEPTH  = 4;

   // One queued fetch: the word address it was read from plus the instruction.
   typedef struct packed {
      logic [c_DEF_ADDR_W-1:0] pc;
      logic [c_DEF_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage : prefetch_pkg
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : prefetch_fifo
//  Brief    : Circular queue of fetch entries with head/tail pointers and an
//             occupancy count. Reset is synchronous, active-low; i_clear
//             empties the queue in one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module prefetch_fifo
   import prefetch_pkg::*;
#(
   parameter  int DEPTH = c_DEF_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_push,
   input  fetch_entry_t     i_pushEntry,
   input  logic             i_pop,
   output fetch_entry_t     o_headEntry,
   output logic [CNT_W-1:0] o_count
);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic w_doPush;
   logic w_doPop;

   // Popping an empty queue is silently ignored.
   assign w_doPush = i_push;
   assign w_doPop  = i_pop && (r_count != '0);

   // Pointer and occupancy bookkeeping; clear and reset both empty the queue.
   always_ff @(posedge clk) begin
      if (!reset || i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_tail <= r_tail + PTR_W'(1);
         if (w_doPop)  r_head <= r_head + PTR_W'(1);
         if (w_doPush && !w_doPop)
            r_count <= r_count + CNT_W'(1);
         else if (!w_doPush && w_doPop)
            r_count <= r_count - CNT_W'(1);
      end
   end

   // Entry storage; contents need no reset because the count gates visibility.
   always_ff @(posedge clk) begin
      if (w_doPush && reset && !i_clear)
         r_mem[r_tail] <= i_pushEntry;
   end

   assign o_headEntry = r_mem[r_head];
   assign o_count     = r_count;

endmodule : prefetch_fifo
`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_prefetch_buffer
//  Brief    : Instruction prefetch queue in front of a 1-cycle-latency
//             instruction memory. Issues sequential fetches while credit is
//             available, flushes on redirect, delivers {pc, instr} to decode
//             over a valid/ready handshake.
//  Config   : define PREFETCH_BYPASS_EN to forward an arriving response
//             straight to the outputs when the queue is empty.
//  Revision : 1.0  initial release
// ============================================================================
module instr_prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int ADDR_W = c_DEF_ADDR_W,
   parameter int DATA_W = c_DEF_DATA_W,
   parameter int DEPTH  = c_DEF_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_next
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] r_fetchPc;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_inflightPc;

   logic [CNT_W-1:0]  w_count;
   fetch_entry_t      w_head;
   fetch_entry_t      w_rspEntry;
   fetch_entry_t      w_outEntry;
   logic              w_credit;
   logic              w_rspValid;
   logic              w_fifoEmpty;
   logic              w_bypass;
   logic              w_push;
   logic              w_pop;

   // Credit counts the outstanding response so every response has a free slot.
   assign w_credit    = (int'(w_count) + int'(r_inflight)) < DEPTH;
   assign w_fifoEmpty = (w_count == '0);

   // A response arriving during a redirect or reset belongs to the old stream.
   assign w_rspValid  = reset && !redirect && r_inflight;
   assign w_rspEntry  = '{pc: r_inflightPc, instr: imem_rdata};

`ifdef PREFETCH_BYPASS_EN
   assign w_bypass = w_rspValid && w_fifoEmpty;
`else
   assign w_bypass = 1'b0;
`endif

   assign imem_req  = reset && (redirect || w_credit);
   assign imem_addr = redirect ? redirect_pc : r_fetchPc;

   assign out_valid   = reset && !redirect && (!w_fifoEmpty || w_bypass);
   assign w_outEntry  = w_bypass ? w_rspEntry : w_head;
   assign out_instr   = out_valid ? w_outEntry.instr : '0;
   assign out_pc      = out_valid ? w_outEntry.pc    : '0;
   assign out_pc_next = out_pc + ADDR_W'(1);

   // A bypassed response consumed by decode this cycle never enters the queue.
   assign w_pop  = out_valid && out_ready && !w_bypass;
   assign w_push = w_rspValid && !(w_bypass && out_ready);

   // Fetch address sequencing and the single outstanding-request tracker.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fetchPc    <= '0;
         r_inflight   <= 1'b0;
         r_inflightPc <= '0;
      end else if (redirect) begin
         r_fetchPc    <= redirect_pc + ADDR_W'(1);
         r_inflight   <= 1'b1;
         r_inflightPc <= redirect_pc;
      end else if (w_credit) begin
         r_fetchPc    <= r_fetchPc + ADDR_W'(1);
         r_inflight   <= 1'b1;
         r_inflightPc <= r_fetchPc;
      end else begin
         r_inflight   <= 1'b0;
      end
   end

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (redirect),
      .i_push      (w_push),
      .i_pushEntry (w_rspEntry),
      .i_pop       (w_pop),
      .o_headEntry (w_head),
      .o_count     (w_count)
   );

endmodule : instr_prefetch_buffer
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_prefetch_buffer
//  Brief    : Self-checking bench for instr_prefetch_buffer: directed
//             scenarios followed by randomized traffic, all compared against
//             a queue-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_prefetch_buffer;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
`ifdef PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } model_entry_t;

   logic              clk;
   logic              reset;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic [ADDR_W-1:0] out_pc_next;

   int nChecks = 0;
   int nErrors = 0;

   // Reference model state
   model_entry_t      mQueue[$];
   int                mInflight;
   logic [ADDR_W-1:0] mInflightPc;
   logic [ADDR_W-1:0] mFetchPc;

   // Values sampled in the most recent step
   logic              sValid;
   logic              sReq;
   logic [ADDR_W-1:0] sAddr;
   logic [ADDR_W-1:0] sPc;
   logic [ADDR_W-1:0] sPcNext;

   instr_prefetch_buffer u_dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_pc_next (out_pc_next)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
      return 32'(a) * 32'h11;
   endfunction

   // Instruction memory: word[n] = n*0x11, one-cycle read latency.
   always @(posedge clk)
      imem_rdata <= imem_req ? memWord(imem_addr) : 32'hDEAD_BEEF;

   task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step(input logic rstN, input logic rdr, input logic [ADDR_W-1:0] rpc, input logic rdy);
      logic         expReq;
      logic         expValid;
      logic         popped;
      model_entry_t head;
      model_entry_t rsp;
      @(negedge clk);
      reset       = rstN;
      redirect    = rdr;
      redirect_pc = rpc;
      out_ready   = rdy;
      #1;
      sValid  = out_valid;
      sReq    = imem_req;
      sAddr   = imem_addr;
      sPc     = out_pc;
      sPcNext = out_pc_next;

      rsp.pc    = mInflightPc;
      rsp.instr = memWord(mInflightPc);
      expReq   = rstN && (rdr || (mQueue.size() + mInflight < DEPTH));
      expValid = rstN && !rdr && (mQueue.size() > 0 || (BYP && mInflight != 0));
      head     = (mQueue.size() > 0) ? mQueue[0] : rsp;

      checkValue("imem_req", 64'(imem_req), 64'(expReq));
      if (expReq)
         checkValue("imem_addr", 64'(imem_addr), 64'(rdr ? rpc : mFetchPc));
      checkValue("out_valid", 64'(out_valid), 64'(expValid));
      if (expValid) begin
         checkValue("out_pc", 64'(out_pc), 64'(head.pc));
         checkValue("out_instr", 64'(out_instr), 64'(head.instr));
         checkValue("out_pc_next", 64'(out_pc_next), 64'(ADDR_W'(head.pc + 1)));
      end
      if (!rstN) begin
         checkValue("rst_out_pc", 64'(out_pc), 64'd0);
         checkValue("rst_out_instr", 64'(out_instr), 64'd0);
      end

      if (!rstN) begin
         mQueue.delete();
         mInflight = 0;
         mFetchPc  = '0;
      end else if (rdr) begin
         mQueue.delete();
         mInflight   = 1;
         mInflightPc = rpc;
         mFetchPc    = rpc + ADDR_W'(1);
      end else begin
         popped = expValid && rdy;
         if (mQueue.size() > 0) begin
            if (popped) void'(mQueue.pop_front());
            if (mInflight != 0) mQueue.push_back(rsp);
         end else if (mInflight != 0 && !popped) begin
            mQueue.push_back(rsp);
         end
         if (expReq) begin
            mInflight   = 1;
            mInflightPc = mFetchPc;
            mFetchPc    = mFetchPc + ADDR_W'(1);
         end else begin
            mInflight = 0;
         end
      end
   endtask

   initial begin : main
      int           reqCount;
      int           found;
      int           latency;
      logic [ADDR_W-1:0] seenPc[$];
      logic [ADDR_W-1:0] pcNextAtTop;

      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b0;
      mInflight   = 0;
      mInflightPc = '0;
      mFetchPc    = '0;

      // Reset, then a free-running stream with decode always ready.
      repeat (3) step(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

      // Stalled decode: exactly DEPTH requests, then silence with head pc 0 held.
      repeat (2) step(1'b0, 1'b0, '0, 1'b0);
      reqCount = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         if (sReq) reqCount++;
         if (i >= 2) checkValue("stall_head_pc", 64'(sPc), 64'd0);
      end
      checkValue("stall_req_count", 64'(reqCount), 64'(DEPTH));

      // Drop one entry, then redirect to 0x40 with three entries queued.
      step(1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b1, 9'h040, 1'b0);
      checkValue("redir_addr", 64'(sAddr), 64'h40);
      checkValue("redir_valid", 64'(sValid), 64'd0);
      found = 0;
      for (int i = 0; i < 5 && found == 0; i++) begin
         step(1'b1, 1'b0, '0, 1'b1);
         if (sValid) begin
            checkValue("redir_first_pc", 64'(sPc), 64'h40);
            found = 1;
         end
      end
      checkValue("redir_delivered", 64'(found), 64'd1);

      // Address wrap from 0x1FF to 0x000.
      step(1'b1, 1'b1, 9'h1FE, 1'b1);
      pcNextAtTop = '1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, '0, 1'b1);
         if (sValid) begin
            seenPc.push_back(sPc);
            if (sPc == 9'h1FF) pcNextAtTop = sPcNext;
         end
      end
      checkValue("wrap_len", 64'(seenPc.size() >= 3), 64'd1);
      if (seenPc.size() >= 3) begin
         checkValue("wrap_pc0", 64'(seenPc[0]), 64'h1FE);
         checkValue("wrap_pc1", 64'(seenPc[1]), 64'h1FF);
         checkValue("wrap_pc2", 64'(seenPc[2]), 64'h000);
      end
      checkValue("wrap_pc_next", 64'(pcNextAtTop), 64'h000);

      // Redirect collides with a valid pop: the pop is dropped.
      step(1'b1, 1'b1, 9'h100, 1'b1);
      checkValue("redir_pop_valid", 64'(sValid), 64'd0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkValue("redir_pop_empty", 64'(sValid), 64'(BYP));

      // Build up entries, then reset mid-stream and measure restart latency.
      repeat (2) step(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         checkValue("midrst_valid", 64'(sValid), 64'd0);
         checkValue("midrst_req", 64'(sReq), 64'd0);
      end
      step(1'b1, 1'b0, '0, 1'b1);
      checkValue("rel_first_addr", 64'(sAddr), 64'd0);
      latency = -1;
      for (int i = 1; i < 5 && latency < 0; i++) begin
         step(1'b1, 1'b0, '0, 1'b1);
         if (sValid) latency = i;
      end
      checkValue("rel_latency", 64'(latency), BYP ? 64'd1 : 64'd2);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 19) == 0),
              ADDR_W'($urandom),
              ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule : tb_instr_prefetch_buffer
`default_nettype wire
